// File: rtl/thread_lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : thread_lsu_pkg
// Purpose  : Core pipeline and LSU state encodings shared across the core.
// Revision : 1.0 - initial release
// ============================================================================
package thread_lsu_pkg;

    typedef enum logic [2:0] {
        CORE_IDLE    = 3'd0,
        CORE_FETCH   = 3'd1,
        CORE_DECODE  = 3'd2,
        CORE_REQUEST = 3'd3,
        CORE_WAIT    = 3'd4,
        CORE_EXECUTE = 3'd5,
        CORE_UPDATE  = 3'd6,
        CORE_DONE    = 3'd7
    } core_state_t;

    // The scheduler watches these codes to decide when a thread may leave WAIT.
    typedef enum logic [1:0] {
        LSU_IDLE       = 2'd0,
        LSU_REQUESTING = 2'd1,
        LSU_WAITING    = 2'd2,
        LSU_DONE       = 2'd3
    } lsu_state_t;

endpackage

`default_nettype wire

// File: rtl/thread_lsu_timeout_counter.sv
`default_nettype none
// ============================================================================
// Module   : lsu_timeout_counter
// Purpose  : Saturating wait counter; flags the increment that reaches the limit.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_incr,
    output logic o_expire
);

    localparam int c_cnt_w = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [c_cnt_w-1:0] c_sat_value =
        (TIMEOUT_CYCLES > 0) ? c_cnt_w'(TIMEOUT_CYCLES) : {c_cnt_w{1'b1}};

    logic [c_cnt_w-1:0] r_count;
    logic [c_cnt_w:0]   w_count_inc;

    assign w_count_inc = {1'b0, r_count} + {{c_cnt_w{1'b0}}, 1'b1};

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_timeout_on
            assign o_expire = i_incr && (w_count_inc >= (c_cnt_w + 1)'(TIMEOUT_CYCLES));
        end else begin : g_timeout_off
            assign o_expire = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_count <= '0;
        end else if (i_incr && (r_count != c_sat_value)) begin
            r_count <= w_count_inc[c_cnt_w-1:0];
        end
    end

endmodule

`default_nettype wire

// File: rtl/thread_lsu.sv
`default_nettype none
// ============================================================================
// Module   : thread_lsu
// Purpose  : Per-thread load/store unit with valid/ready memory handshake.
// Revision : 1.0 - initial release
// ============================================================================
module thread_lsu
    import thread_lsu_pkg::*;
#(
    parameter int ADDR_BITS      = 8,
    parameter int DATA_BITS      = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [2:0]           core_state,
    input  logic                 decoded_mem_read_enable,
    input  logic                 decoded_mem_write_enable,
    input  logic [7:0]           rs,
    input  logic [7:0]           rt,
    output logic                 mem_read_valid,
    output logic [ADDR_BITS-1:0] mem_read_address,
    input  logic                 mem_read_ready,
    input  logic [DATA_BITS-1:0] mem_read_data,
    output logic                 mem_write_valid,
    output logic [ADDR_BITS-1:0] mem_write_address,
    output logic [DATA_BITS-1:0] mem_write_data,
    input  logic                 mem_write_ready,
    output logic [1:0]           lsu_state,
    output logic [DATA_BITS-1:0] lsu_out,
    output logic                 lsu_error
);

    lsu_state_t          r_state;
    logic [ADDR_BITS-1:0] r_addr;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_is_read;
    logic                 r_read_valid;
    logic                 r_write_valid;
    logic [DATA_BITS-1:0] r_out;
    logic                 r_error;

    logic w_ready;
    logic w_waiting;
    logic w_expire;

    // Only the ready of the channel actually in use can complete the request.
    assign w_ready   = r_is_read ? mem_read_ready : mem_write_ready;
    assign w_waiting = (r_state == LSU_WAITING);

    lsu_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (!w_waiting),
        .i_incr   (w_waiting && !w_ready),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= LSU_IDLE;
            r_addr        <= '0;
            r_data        <= '0;
            r_is_read     <= 1'b0;
            r_read_valid  <= 1'b0;
            r_write_valid <= 1'b0;
            r_out         <= '0;
            r_error       <= 1'b0;
        end else if (!enable) begin
            r_state       <= LSU_IDLE;
            r_read_valid  <= 1'b0;
            r_write_valid <= 1'b0;
        end else begin
            case (r_state)
                LSU_IDLE: begin
                    if ((core_state == CORE_REQUEST) &&
                        (decoded_mem_read_enable || decoded_mem_write_enable)) begin
                        r_addr    <= ADDR_BITS'(rs);
                        r_data    <= DATA_BITS'(rt);
                        r_is_read <= decoded_mem_read_enable;
                        r_error   <= 1'b0;
                        r_state   <= LSU_REQUESTING;
                    end
                end
                LSU_REQUESTING: begin
                    r_read_valid  <= r_is_read;
                    r_write_valid <= !r_is_read;
                    r_state       <= LSU_WAITING;
                end
                LSU_WAITING: begin
                    if (w_ready) begin
                        if (r_is_read) begin
                            r_out <= mem_read_data;
                        end
                        r_read_valid  <= 1'b0;
                        r_write_valid <= 1'b0;
                        r_state       <= LSU_DONE;
                    end else if (w_expire) begin
                        if (r_is_read) begin
                            r_out <= '0;
                        end
                        r_error       <= 1'b1;
                        r_read_valid  <= 1'b0;
                        r_write_valid <= 1'b0;
                        r_state       <= LSU_DONE;
                    end
                end
                LSU_DONE: begin
                    if (core_state == CORE_UPDATE) begin
                        r_state <= LSU_IDLE;
                    end
                end
                default: r_state <= LSU_IDLE;
            endcase
        end
    end

    assign mem_read_valid    = r_read_valid;
    assign mem_read_address  = r_addr;
    assign mem_write_valid   = r_write_valid;
    assign mem_write_address = r_addr;
    assign mem_write_data    = r_data;
    assign lsu_state         = r_state;
    assign lsu_out           = r_out;
    assign lsu_error         = r_error;

endmodule

`default_nettype wire
